// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round-count constants and inverse-round primitives
//
// Purpose: common definitions for the iterative AES decryption controller.
//   NR_128/NR_192/NR_256 : legal round counts
//   state_t              : controller FSM state (IDLE/ROUND/DONE)
//   block_t              : 128-bit AES block, byte 0 in [127:120], column-major
//   rk_idx_width()       : bits needed to index round keys 0..NR
//   inv_shift_rows/inv_sub_bytes/add_round_key/inv_mix_columns : round primitives
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [127:0] block_t;

  function automatic int rk_idx_width(input int nr);
    return $clog2(nr + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), avoiding a 256-entry table.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  // Row r rotates right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic block_t add_round_key(input block_t s, input block_t rk);
    return s ^ rk;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t     o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b) ^
                                gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational single AES inverse round
//
// Purpose: one inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Ports:
//   st      in  128  current state
//   rk      in  128  round key for this round
//   last    in  1    final round: InvMixColumns bypassed
//   st_next out 128  state after the round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_next
);

  block_t shifted;
  block_t subbed;
  block_t keyed;

  assign shifted = inv_shift_rows(st);
  assign subbed  = inv_sub_bytes(shifted);
  assign keyed   = add_round_key(subbed, rk);
  assign st_next = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES decryption controller, one inverse round per clock
//
// Purpose: accepts a ciphertext block, applies the key-NR AddRoundKey on accept, then runs
// NR inverse rounds (keys NR-1..0) and presents the plaintext until out_ready.
// Optional feature macro: AES_INV_CTRL_ABORT_EN adds the abort input.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   ciphertext handshake, data_in (byte 0 in [127:120])
//   rk_idx/rk_data      round-key index (combinational) and key returned same cycle
//   out_valid/out_ready plaintext handshake, data_out (0 outside DONE)
//   busy                high in ROUND and DONE
//   abort               (AES_INV_CTRL_ABORT_EN only) drop current block, return to IDLE
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   data_in,
  output logic [RKW-1:0] rk_idx,
  input  logic [127:0]   rk_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   data_out,
  output logic           busy
`ifdef AES_INV_CTRL_ABORT_EN
  ,
  input  logic           abort
`endif
);

  if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
    $fatal(1, "aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end
  if (RKW < rk_idx_width(NR)) begin : g_bad_rkw
    $fatal(1, "aes_inv_round_ctrl: RKW too narrow to index round key NR");
  end

  localparam logic [RKW-1:0] NR_IDX = RKW'(NR);
  localparam logic [RKW-1:0] NR_M1  = RKW'(NR - 1);

  state_t         state;
  logic [RKW-1:0] round_cnt;
  block_t         st;
  block_t         round_out;
  logic           abort_i;

`ifdef AES_INV_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  aes_inv_round u_round (
    .st      (st),
    .rk      (rk_data),
    .last    (round_cnt == '0),
    .st_next (round_out)
  );

  // Key NR for the initial whitening, the live round key while iterating.
  always_comb begin
    rk_idx = '0;
    case (state)
      IDLE:    rk_idx = NR_IDX;
      ROUND:   rk_idx = round_cnt;
      default: rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
    end else if (abort_i) begin
      // Overrides everything, including an in_valid presented in IDLE.
      state     <= IDLE;
      round_cnt <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st        <= add_round_key(data_in, rk_data);
            round_cnt <= NR_M1;
            state     <= ROUND;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ROUND: begin
          st <= round_out;
          if (round_cnt == '0) begin
            // data_out only ever loads the finished plaintext.
            state     <= DONE;
            out_valid <= 1'b1;
            data_out  <= round_out;
          end else begin
            round_cnt <= round_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            st        <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
